// File: rtl/delta_batch_accumulator_pkg.sv
// Shared network definitions: lane-width helpers and batch FSM state encoding.
package delta_batch_accumulator_pkg;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  // Delta lane width of a hidden layer fed by NN neurons.
  function automatic int hidden_lane_w(input int nn, input int wc, input int wd);
    return $clog2(nn) + wc + wd;
  endfunction

  // Delta lane width of the output layer.
  function automatic int output_lane_w(input int wc, input int wd);
    return wc + wd;
  endfunction

  // Accumulator width: NB full-scale samples never overflow.
  function automatic int acc_w(input int wi, input int nb);
    return wi + $clog2(nb);
  endfunction

endpackage

// File: rtl/delta_lane_acc.sv
// One lane of the mini-batch accumulator: sign-extend, sum, and floor-mean on the last sample.
module delta_lane_acc
  import delta_batch_accumulator_pkg::*;
#(
  parameter int WI = 10,
  parameter int NB = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          add,
  input  logic          fin,
  input  logic [WI-1:0] din,
  output logic [WI-1:0] dout
);

  localparam int LNB = $clog2(NB);
  localparam int WA  = acc_w(WI, NB);

  logic signed [WA-1:0] acc;
  logic signed [WA-1:0] ext;
  logic signed [WA-1:0] sum;
  logic        [WI-1:0] mean;

  assign ext  = WA'($signed(din));
  assign sum  = acc + ext;
  // Arithmetic shift floors toward -inf; the mean always fits back into WI bits.
  assign mean = WI'(sum >>> LNB);

  // Accumulate accepted samples; din only reaches acc when add is set, so idle X never leaks in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc  <= '0;
      dout <= '0;
    end else begin
      if (clr)      acc <= '0;
      else if (add) acc <= sum;
      if (fin) dout <= mean;
    end
  end

endmodule

// File: rtl/delta_batch_accumulator.sv
// Mini-batch mean of NB delta vectors between the delta stage and the weight-update stage.
module delta_batch_accumulator
  import delta_batch_accumulator_pkg::*;
#(
  parameter int NC = 4,
  parameter int WI = 10,
  parameter int NB = 4
) (
  input  logic           iCLK,
  input  logic           iRST,
  input  logic           iValid_AS,
  output logic           oReady_AS,
  input  logic [NC*WI-1:0] iData_AS,
  output logic           oValid_BS,
  input  logic           iReady_BS,
  output logic [NC*WI-1:0] oData_BS
);

  localparam int LNB = $clog2(NB);
  localparam int CW  = (LNB > 0) ? LNB : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          take;
  logic          last;
  logic          done;

  // Ready/valid are pure decodes of the state register: no path from iReady_BS to oReady_AS.
  assign oReady_AS = (state == ST_ACC);
  assign oValid_BS = (state == ST_OUT);
  assign take      = iValid_AS & oReady_AS;
  // With NB==1 the counter never leaves 0, so every sample closes a batch.
  assign last      = (cnt == CW'(NB - 1));
  assign done      = take & last;

  // Batch FSM: count accepted samples, then hold the mean until downstream takes it.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state <= ST_ACC;
      cnt   <= '0;
    end else begin
      case (state)
        ST_ACC: if (take) begin
          if (last) begin
            state <= ST_OUT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_OUT: if (iReady_BS) state <= ST_ACC;
        default: state <= ST_ACC;
      endcase
    end
  end

  for (genvar k = 0; k < NC; k++) begin : g_lane
    delta_lane_acc #(.WI(WI), .NB(NB)) u_lane (
      .clk  (iCLK),
      .rst_n(iRST),
      .clr  (done),
      .add  (take),
      .fin  (done),
      .din  (iData_AS[k*WI +: WI]),
      .dout (oData_BS[k*WI +: WI])
    );
  end

endmodule

// File: tb/tb_delta_batch_accumulator.sv
// Scoreboard bench: NB=4 and NB=1 instances checked against a floor-mean reference model.
module tb_delta_batch_accumulator;

  localparam int NC = 2;
  localparam int WI = 8;
  localparam int NB = 4;

  typedef logic [NC*WI-1:0] vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic in_v, in_r, out_v, out_r;
  vec_t in_d, out_d;
  logic in_v1, in_r1, out_v1, out_r1;
  vec_t in_d1, out_d1;

  int checks = 0;
  int failures = 0;
  bit rdy_rand = 1'b0;

  vec_t exp_q[$];
  vec_t exp_q1[$];

  delta_batch_accumulator #(.NC(NC), .WI(WI), .NB(NB)) dut (
    .iCLK(clk), .iRST(rst),
    .iValid_AS(in_v), .oReady_AS(in_r), .iData_AS(in_d),
    .oValid_BS(out_v), .iReady_BS(out_r), .oData_BS(out_d)
  );

  delta_batch_accumulator #(.NC(NC), .WI(WI), .NB(1)) dut1 (
    .iCLK(clk), .iRST(rst),
    .iValid_AS(in_v1), .oReady_AS(in_r1), .iData_AS(in_d1),
    .oValid_BS(out_v1), .iReady_BS(out_r1), .oData_BS(out_d1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int a, input int b);
    vec_t v;
    v[0 +: WI]  = WI'(a);
    v[WI +: WI] = WI'(b);
    return v;
  endfunction

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Reference model + monitor for the NB instance.
  int   sums[NC];
  int   nacc = 0;
  bit   was_rst = 0, done_prev = 0, stall_prev = 0;
  vec_t stall_data;
  always @(negedge clk) begin
    vec_t e;
    if (was_rst) begin
      chk("rst_valid", out_v, 0);
      chk("rst_data", out_d, 0);
      chk("rst_ready", in_r, 1);
    end
    if (done_prev) chk("latency_valid", out_v, 1);
    if (stall_prev) begin
      chk("hold_valid", out_v, 1);
      chk("hold_data", out_d, stall_data);
    end
    was_rst = 0; done_prev = 0; stall_prev = 0;
    if (!rst) begin
      was_rst = 1;
      nacc = 0;
      for (int k = 0; k < NC; k++) sums[k] = 0;
      exp_q.delete();
    end else begin
      chk("ready_vs_valid", in_r, !out_v);
      if (out_v && out_r) begin
        if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("mean", out_d, e);
        end
      end else if (out_v) begin
        stall_prev = 1;
        stall_data = out_d;
      end
      if (in_v && in_r) begin
        for (int k = 0; k < NC; k++) sums[k] += $signed(in_d[k*WI +: WI]);
        nacc++;
        if (nacc == NB) begin
          for (int k = 0; k < NC; k++) begin
            e[k*WI +: WI] = WI'(floor_div(sums[k], NB));
            sums[k] = 0;
          end
          exp_q.push_back(e);
          nacc = 0;
          done_prev = 1;
        end
      end
    end
  end

  // Monitor for the NB=1 instance: each sample reappears unchanged one cycle later.
  bit lat1_prev = 0;
  always @(negedge clk) begin
    vec_t e;
    if (lat1_prev) chk("nb1_latency", out_v1, 1);
    lat1_prev = 0;
    if (!rst) exp_q1.delete();
    else begin
      chk("nb1_ready_vs_valid", in_r1, !out_v1);
      if (out_v1 && out_r1) begin
        if (exp_q1.size() == 0) chk("nb1_unexpected", 1, 0);
        else begin
          e = exp_q1.pop_front();
          chk("nb1_pass", out_d1, e);
        end
      end
      if (in_v1 && in_r1) begin
        exp_q1.push_back(in_d1);
        lat1_prev = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) begin
      out_r  = 1'($urandom_range(0, 1));
      out_r1 = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input bit which, input vec_t d);
    bit ok = 0;
    if (which) begin in_v1 = 1; in_d1 = d; end
    else begin in_v = 1; in_d = d; end
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge clk);
      ok = which ? in_r1 : in_r;
      tick();
    end
    if (which) begin in_v1 = 0; in_d1 = 'x; end
    else begin in_v = 0; in_d = 'x; end
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit ok = 0;
    rdy_rand = 0;
    out_r = 1; out_r1 = 1;
    for (int t = 0; t < 64 && !ok; t++) begin
      tick();
      ok = (exp_q.size() == 0) && (exp_q1.size() == 0) && !out_v && !out_v1;
    end
    if (!ok) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    rst = 0; in_v = 1; in_d = mk(5, 5); out_r = 0;
    in_v1 = 0; in_d1 = 'x; out_r1 = 1;
    // 1: reset with valid held high
    tick(); tick();
    rst = 1; in_v = 0; in_d = 'x;
    // 2: four back-to-back vectors
    send(0, mk(10, -1)); send(0, mk(20, -2)); send(0, mk(30, -3)); send(0, mk(40, -4));
    @(negedge clk);
    chk("s2_mean", out_d, mk(25, -3));
    chk("s2_ready", in_r, 0);
    // 3: backpressure with valid offered
    tick();
    in_v = 1; in_d = mk(1, 1);
    idle(5);
    in_v = 0; in_d = 'x;
    out_r = 1;
    tick();
    @(negedge clk);
    chk("s3_back_to_acc", in_r, 1);
    // 4: extremes
    repeat (4) send(0, mk(-128, -128));
    repeat (4) send(0, mk(127, -128));
    repeat (4) send(0, mk(127, 127));
    drain();
    // 5: gapped input
    for (int i = 0; i < 4; i++) begin
      send(0, mk(8, 8));
      idle($urandom_range(0, 3));
    end
    drain();
    // 6: reset mid-batch discards the partial batch
    send(0, mk(100, 100)); send(0, mk(100, 100));
    rst = 0; tick(); rst = 1;
    for (int i = 0; i < 4; i++) send(0, mk(4, 4));
    @(negedge clk);
    chk("s6_after_reset", out_d, mk(4, 4));
    drain();
    // NB=1 passthrough
    send(1, mk(7, -7));
    @(negedge clk);
    chk("nb1_direct", out_d1, mk(7, -7));
    drain();
    // random traffic with random downstream stalls
    rdy_rand = 1;
    for (int i = 0; i < 48; i++) begin
      send(0, mk(int'($urandom_range(0, 255)), int'($urandom_range(0, 255))));
      if (i % 2 == 0) send(1, mk(int'($urandom_range(0, 255)), int'($urandom_range(0, 255))));
      idle($urandom_range(0, 2));
    end
    drain();
    chk("final_queue", exp_q.size(), 0);
    chk("final_queue_nb1", exp_q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/delta_batch_accumulator.md
Name: delta_batch_accumulator

Overview:
Receiver for the per-sample delta vectors that the delta stage emits on its BS side. It sums NB consecutive delta vectors lane-wise (mini-batch) and emits their mean as one vector to the weight-update stage. It sits between the delta stage and the weight-update stage, with a valid/ready handshake on both sides.

Parameters:
NC, 4, number of lanes (neurons in the current layer)
WI, 10, width of one signed delta lane. The hidden-layer delta stage uses $clog2(NN)+WC+WD; the output layer uses WC+WD.
NB, 4, samples per mini-batch; power of two, >= 1
LNB, $clog2(NB), derived; not overridden
WA, WI+LNB, derived accumulator lane width

Ports:
iCLK  input  1  clock, all logic on rising edge
iRST  input  1  reset, synchronous, active-low
iValid_AS  input  1  upstream delta vector valid
oReady_AS  output  1  ready for upstream delta vector
iData_AS  input  NC*WI  NC signed delta lanes; lane k at [k*WI +: WI]
oValid_BS  output  1  batch-mean vector valid
iReady_BS  input  1  downstream ready
oData_BS  output  NC*WI  NC signed mean lanes; lane k at [k*WI +: WI]

Behaviour:
- Reset (iRST==0 at a rising edge):
  - State goes to ACC.
  - Sample counter = 0, all accumulators = 0.
  - oValid_BS = 0, oData_BS = 0, oReady_AS = 1 from the next cycle.
  - Reset overrides any handshake in that cycle. A partial batch is discarded.
- States: ACC, OUT.
- oReady_AS = (state==ACC); this is a registered state decode with no combinational path from iReady_BS.
- oValid_BS = (state==OUT).
- ACC, input handshake (iValid_AS & oReady_AS):
  - Each lane: acc[k] <= acc[k] + sign_extend(lane k to WA).
  - cnt <= cnt+1.
  - No handshake means no change; idle cycles never count.
- ACC, handshake with cnt==NB-1:
  - oData_BS lane k <= (acc[k] + lane k) >>> LNB, an arithmetic shift (floor toward -inf).
  - The low WI bits of the shifted value are taken; this is exact because the mean lies within the WI range.
  - State <= OUT, cnt <= 0, acc <= 0.
- Latency: oValid_BS rises in the cycle after the NB-th input handshake.
- OUT:
  - oData_BS is held stable and oValid_BS stays high until iReady_BS==1.
  - On that edge state <= ACC.
  - No input is accepted while in OUT (bubble of at least one cycle per batch).
- Throughput: at most NB vectors per NB+1 cycles.
- NB==1: every input is passed through with 1-cycle latency and no shift. The counter is degenerate (the cnt==NB-1 test is always true).
- No overflow is possible: the WA width covers NB full-scale samples.
- An iData_AS change without a handshake is ignored.
- X on iData_AS while iValid_AS==0 must not propagate into the accumulators.

Decomposition:
- Shared network package holds:
  - Lane-width functions: hidden-layer width $clog2(NN)+WC+WD, output-layer width WC+WD.
  - A function computing WA from WI and NB.
  - State encoding constants ST_ACC and ST_OUT.
- One natural sub-module: delta_lane_acc (one lane).
  - Contents: WA-bit accumulator, sign extension, final add-and-shift.
  - Controls: clear, add, and finish enables, driven from the top-level FSM/counter.
  - The top level instantiates it NC times in a generate loop.

Test Plan:
1. Reset (NC=2, WI=8, NB=4): hold iRST=0 for 2 cycles with iValid_AS=1 -> oValid_BS=0, oData_BS=0, oReady_AS=1; no sample counted.
2. Four back-to-back vectors, lane0=10,20,30,40 and lane1=-1,-2,-3,-4 -> one cycle after the 4th handshake, oValid_BS=1, lane0=25, lane1=-3 (floor of -2.5); oReady_AS=0.
3. Backpressure: after scenario 2, hold iReady_BS=0 for 5 cycles with iValid_AS=1 -> oData_BS stable, oValid_BS=1, oReady_AS=0, no input consumed; iReady_BS=1 -> ACC next cycle.
4. Extremes: four vectors of -128 then four of 127 -> outputs -128 then 127; no wrap.
5. Gapped input: iValid_AS toggled with 0-3 idle cycles between four samples of 8 -> a single output of 8, emitted only after the 4th handshake.
6. Reset mid-batch: 2 samples of 100, pulse iRST=0, then 4 samples of 4 -> output 4 (pre-reset data discarded). Repeat with NB=1: input 7 -> output 7 one cycle later.
